bit40_split_bit8: RTL and testbench
===================================

// Module: bit40_split_bit8
// PURPOSE
//   Transmit-side counterpart of the 8-to-40-bit UART receive packer.
//   - Accepts one WORD_W-bit word and serializes it MSB byte first into a stream of bytes.
//   - Pulses each byte into the UART transmitter (TX_EN style) and waits for that
//     transmitter's done pulse before sending the next byte.
//   - Sits between the result/command logic and uart_tx, so a host receives the same 5-byte framing it sends.
// PARAMETERS
//   NBYTES      5    bytes per word; WORD_W = 8*NBYTES
//   GAP_CYC     0    idle clk cycles inserted between a byte's tx_done and the next start pulse (0 = none)
//   TIMEOUT_CYC 0    max clk cycles to wait for tx_done per byte; 0 = wait forever
// PORTS
//   clk             in   1       system clock, all logic on rising edge
//   rst             in   1       synchronous reset, active-high
//   bit40_in        in   WORD_W  word to transmit
//   bit40_in_valid  in   1       word present
//   bit40_in_ready  out  1       block idle, word accepted when valid&ready
//   bit8_out        out  8       byte to UART TX (TX_DATA)
//   bit8_out_valid  out  1       1-cycle start pulse to UART TX (TX_EN)
//   tx_done         in   1       1-cycle pulse from UART TX: current byte fully sent
//   word_done       out  1       1-cycle pulse: last byte of word acknowledged
//   tx_err          out  1       1-cycle pulse: tx_done timeout, word aborted
//   busy            out  1       high in any state other than IDLE
// BEHAVIOUR
//   Reset (rst=1 at clk edge)
//   - All outputs 0 except bit40_in_ready=1.
//   - State IDLE; shift register and counters cleared.
//   - Reset mid-word discards the word: no word_done, no tx_err.
//   FSM: IDLE -> SEND -> WAIT -> (GAP ->) SEND ... -> IDLE
//   - IDLE: ready=1.
//     - On valid&ready at edge N: latch word into shift reg, byte_idx=0, ready=0 from N+1, -> SEND.
//     - Valid while not ready is ignored; there is no queue, and the source holds valid.
//   - SEND (1 cycle): bit8_out=shreg[WORD_W-1 -: 8], bit8_out_valid=1 for this cycle only.
//     - First start pulse is therefore in cycle N+1 (latency 1 clk from accept).
//     - Timeout counter cleared. -> WAIT.
//   - WAIT: bit8_out held stable, valid=0, timeout counter increments each cycle.
//     - tx_done & byte_idx==NBYTES-1: word_done=1 next cycle, -> IDLE. Ready returns with the word_done cycle.
//     - tx_done otherwise: shreg<<=8, byte_idx++, -> GAP if GAP_CYC>0 else SEND.
//       Next start pulse is 1 cycle after tx_done when GAP_CYC=0.
//     - TIMEOUT_CYC>0 and counter reaches TIMEOUT_CYC with no tx_done:
//       tx_err=1 next cycle, word aborted, -> IDLE.
//       tx_done and timeout in the same cycle: tx_done wins.
//   - GAP: count GAP_CYC cycles, then -> SEND.
//   Boundaries
//   - tx_done in IDLE, SEND or GAP: ignored (a spurious pulse never advances byte_idx).
//   - bit8_out keeps the last byte after the word completes, until the next SEND.
//   - byte_idx width clog2(NBYTES); never wraps beyond NBYTES-1.
//   - Byte order matches the receive packer: word[39:32] goes first, word[7:0] goes last.
// TESTING
//   1. Reset, then send 40'h11_22_33_44_55, tx_done 10 cycles after each pulse
//      -> bytes 11,22,33,44,55 in order; 5 start pulses; 1 word_done after the 5th tx_done.
//   2. Back-to-back words A1..A5 then B1..B5, valid held high
//      -> second word accepted in the cycle ready rises; 10 bytes, 2 word_done, no loss.
//   3. GAP_CYC=3 -> exactly 3 idle cycles between each tx_done and the next start pulse;
//      GAP_CYC=0 -> exactly 1 cycle.
//   4. TIMEOUT_CYC=20, suppress tx_done after byte 2
//      -> tx_err after 20 cycles, no word_done, ready=1, next word sent cleanly.
//   5. Spurious tx_done in IDLE and GAP, plus tx_done coincident with the start pulse
//      -> ignored, byte sequence unchanged.
//   6. Assert rst during byte 3 wait -> outputs reset next cycle, no word_done;
//      new word 0xDE_AD_BE_EF_01 sent from byte DE.

Source files
------------

// File: rtl/bit40_split_bit8.sv
// Serializes one NBYTES-byte word MSB byte first into a UART transmitter,
// handshaking each byte with the transmitter's done pulse.
module bit40_split_bit8 #(
    parameter int NBYTES      = 5,
    parameter int GAP_CYC     = 0,
    parameter int TIMEOUT_CYC = 0,
    localparam int WORD_W     = 8 * NBYTES
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [WORD_W-1:0] bit40_in,
    input  logic              bit40_in_valid,
    output logic              bit40_in_ready,
    output logic [7:0]        bit8_out,
    output logic              bit8_out_valid,
    input  logic              tx_done,
    output logic              word_done,
    output logic              tx_err,
    output logic              busy
);
    localparam int IDX_W = (NBYTES > 1) ? $clog2(NBYTES) : 1;
    localparam int TO_W  = $clog2(TIMEOUT_CYC + 2);
    localparam int GAP_W = $clog2(GAP_CYC + 2);
    localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(NBYTES - 1);
    localparam logic [TO_W-1:0]  TO_LIMIT  = TO_W'((TIMEOUT_CYC > 0) ? TIMEOUT_CYC - 1 : 0);
    localparam logic [GAP_W-1:0] GAP_LIMIT = GAP_W'((GAP_CYC > 0) ? GAP_CYC - 1 : 0);

    typedef enum logic [1:0] {S_IDLE, S_SEND, S_WAIT, S_GAP} state_t;

    state_t            state_reg;
    logic [WORD_W-1:0] shreg_reg;
    logic [WORD_W-1:0] shreg_next;
    logic [IDX_W-1:0]  byte_idx_reg;
    logic [TO_W-1:0]   to_cnt_reg;
    logic [GAP_W-1:0]  gap_cnt_reg;
    logic [7:0]        byte_reg;
    logic              valid_reg;
    logic              ready_reg;
    logic              word_done_reg;
    logic              tx_err_reg;

    // Shifted view lets the next byte be launched in the same edge that acknowledges the current one.
    assign shreg_next = shreg_reg << 8;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg     <= S_IDLE;
            shreg_reg     <= '0;
            byte_idx_reg  <= '0;
            to_cnt_reg    <= '0;
            gap_cnt_reg   <= '0;
            byte_reg      <= '0;
            valid_reg     <= 1'b0;
            ready_reg     <= 1'b1;
            word_done_reg <= 1'b0;
            tx_err_reg    <= 1'b0;
        end else begin
            valid_reg     <= 1'b0;
            word_done_reg <= 1'b0;
            tx_err_reg    <= 1'b0;
            case (state_reg)
                S_IDLE: begin
                    if (bit40_in_valid && ready_reg) begin
                        shreg_reg    <= bit40_in;
                        byte_idx_reg <= '0;
                        byte_reg     <= bit40_in[WORD_W-1 -: 8];
                        valid_reg    <= 1'b1;
                        ready_reg    <= 1'b0;
                        state_reg    <= S_SEND;
                    end
                end
                S_SEND: begin
                    to_cnt_reg <= '0;
                    state_reg  <= S_WAIT;
                end
                S_WAIT: begin
                    if (tx_done) begin
                        if (byte_idx_reg == LAST_IDX) begin
                            word_done_reg <= 1'b1;
                            ready_reg     <= 1'b1;
                            state_reg     <= S_IDLE;
                        end else begin
                            shreg_reg    <= shreg_next;
                            byte_idx_reg <= byte_idx_reg + IDX_W'(1);
                            if (GAP_CYC == 0) begin
                                byte_reg  <= shreg_next[WORD_W-1 -: 8];
                                valid_reg <= 1'b1;
                                state_reg <= S_SEND;
                            end else begin
                                gap_cnt_reg <= '0;
                                state_reg   <= S_GAP;
                            end
                        end
                    end else if (TIMEOUT_CYC > 0) begin
                        // The timeout only fires when no done arrives in the final counted cycle.
                        if (to_cnt_reg == TO_LIMIT) begin
                            tx_err_reg <= 1'b1;
                            ready_reg  <= 1'b1;
                            state_reg  <= S_IDLE;
                        end else begin
                            to_cnt_reg <= to_cnt_reg + TO_W'(1);
                        end
                    end
                end
                S_GAP: begin
                    if (gap_cnt_reg == GAP_LIMIT) begin
                        byte_reg  <= shreg_reg[WORD_W-1 -: 8];
                        valid_reg <= 1'b1;
                        state_reg <= S_SEND;
                    end else begin
                        gap_cnt_reg <= gap_cnt_reg + GAP_W'(1);
                    end
                end
                default: state_reg <= S_IDLE;
            endcase
        end
    end

    assign bit40_in_ready = ready_reg;
    assign bit8_out       = byte_reg;
    assign bit8_out_valid = valid_reg;
    assign word_done      = word_done_reg;
    assign tx_err         = tx_err_reg;
    assign busy           = (state_reg != S_IDLE);
endmodule

// File: tb/tb_bit40_split_bit8.sv
// Drives two splitters (no gap with 20-cycle timeout, and 3-cycle gap) acting as
// the word source and the UART transmitter, checking bytes and timing.
module tb_bit40_split_bit8;
    logic        clk = 1'b0;
    logic        rst;
    logic [39:0] in_w [2];
    logic        v [2];
    logic        done [2];
    logic        rdy [2];
    logic [7:0]  b8 [2];
    logic        vo [2];
    logic        wd [2];
    logic        err [2];
    logic        busy [2];

    int n_chk = 0;
    int n_fail = 0;
    int wd_cnt [2] = '{0, 0};
    int err_cnt [2] = '{0, 0};
    int pulse_cnt [2] = '{0, 0};
    int exp_wd [2] = '{0, 0};
    int exp_err [2] = '{0, 0};
    int exp_p [2] = '{0, 0};

    always #5 clk = ~clk;

    bit40_split_bit8 #(.NBYTES(5), .GAP_CYC(0), .TIMEOUT_CYC(20)) dut0 (
        .clk(clk), .rst(rst), .bit40_in(in_w[0]), .bit40_in_valid(v[0]),
        .bit40_in_ready(rdy[0]), .bit8_out(b8[0]), .bit8_out_valid(vo[0]),
        .tx_done(done[0]), .word_done(wd[0]), .tx_err(err[0]), .busy(busy[0]));

    bit40_split_bit8 #(.NBYTES(5), .GAP_CYC(3), .TIMEOUT_CYC(0)) dut1 (
        .clk(clk), .rst(rst), .bit40_in(in_w[1]), .bit40_in_valid(v[1]),
        .bit40_in_ready(rdy[1]), .bit8_out(b8[1]), .bit8_out_valid(vo[1]),
        .tx_done(done[1]), .word_done(wd[1]), .tx_err(err[1]), .busy(busy[1]));

    // Pulse counters observed mid-cycle, compared against the bench's own tallies at the end.
    always @(negedge clk) begin
        for (int i = 0; i < 2; i++) begin
            if (wd[i])  wd_cnt[i]++;
            if (err[i]) err_cnt[i]++;
            if (vo[i])  pulse_cnt[i]++;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    function automatic int gap_of(input int d);
        return (d == 1) ? 3 : 0;
    endfunction

    // mode: 0 normal, 1 withhold tx_done at byte stop_k (timeout), 2 reset during byte stop_k wait
    task automatic send_word(input int d, input logic [39:0] w, input int dly, input int mode,
                             input int stop_k, input bit spur, input bit keep);
        int waitc;
        logic [7:0] exp_b;
        if (spur && !v[d]) begin
            done[d] = 1'b1; tick(); done[d] = 1'b0;
            chk("idle_spur_busy", busy[d], 1'b0);
        end
        in_w[d] = w;
        v[d] = 1'b1;
        waitc = 0;
        while (rdy[d] !== 1'b1 && waitc < 50) begin
            tick();
            waitc++;
        end
        chk("accept_wait", waitc < 50, 1'b1);
        tick();
        if (!keep) v[d] = 1'b0;
        for (int k = 0; k < 5; k++) begin
            exp_b = 8'((w >> (8 * (4 - k))) & 40'hFF);
            chk("start_pulse", vo[d], 1'b1);
            chk("byte", b8[d], exp_b);
            chk("busy", busy[d], 1'b1);
            chk("ready_low", rdy[d], 1'b0);
            exp_p[d]++;
            if (mode == 1 && k == stop_k) begin
                for (int c = 1; c <= 20; c++) begin
                    tick();
                    chk("no_early_err", err[d], 1'b0);
                end
                tick();
                chk("tx_err", err[d], 1'b1);
                chk("err_ready", rdy[d], 1'b1);
                chk("err_no_wd", wd[d], 1'b0);
                exp_err[d]++;
                tick();
                chk("err_single", err[d], 1'b0);
                $display("word d=%0d %h aborted by timeout at byte %0d", d, w, k);
                return;
            end
            if (mode == 2 && k == stop_k) begin
                repeat (3) tick();
                rst = 1'b1; tick(); rst = 1'b0;
                chk("rst_byte", b8[d], 8'h00);
                chk("rst_valid", vo[d], 1'b0);
                chk("rst_ready", rdy[d], 1'b1);
                chk("rst_busy", busy[d], 1'b0);
                chk("rst_wd", wd[d], 1'b0);
                chk("rst_err", err[d], 1'b0);
                $display("word d=%0d %h discarded by reset at byte %0d", d, w, k);
                return;
            end
            for (int c = 0; c < dly; c++) begin
                done[d] = spur && (c == 0);
                tick();
                done[d] = 1'b0;
                chk("wait_valid", vo[d], 1'b0);
                chk("wait_byte", b8[d], exp_b);
            end
            done[d] = 1'b1; tick(); done[d] = 1'b0;
            if (k == 4) begin
                chk("word_done", wd[d], 1'b1);
                chk("done_ready", rdy[d], 1'b1);
                chk("done_busy", busy[d], 1'b0);
                chk("last_byte_held", b8[d], w[7:0]);
                exp_wd[d]++;
            end else begin
                chk("no_wd", wd[d], 1'b0);
                for (int g = 0; g < gap_of(d); g++) begin
                    chk("gap_valid", vo[d], 1'b0);
                    done[d] = spur && (g == 0);
                    tick();
                    done[d] = 1'b0;
                end
            end
        end
        $display("word d=%0d %h sent dly=%0d spur=%0d", d, w, dly, spur);
    endtask

    initial begin
        logic [39:0] rw;
        rst = 1'b1;
        for (int i = 0; i < 2; i++) begin
            in_w[i] = '0; v[i] = 1'b0; done[i] = 1'b0;
        end
        repeat (3) tick();
        for (int i = 0; i < 2; i++) begin
            chk("reset_ready", rdy[i], 1'b1);
            chk("reset_valid", vo[i], 1'b0);
            chk("reset_byte", b8[i], 8'h00);
            chk("reset_busy", busy[i], 1'b0);
            chk("reset_wd", wd[i], 1'b0);
            chk("reset_err", err[i], 1'b0);
        end
        rst = 1'b0;
        tick();

        send_word(0, 40'h11_22_33_44_55, 10, 0, 0, 1'b0, 1'b0);
        tick();
        chk("byte_kept_after_word", b8[0], 8'h55);
        chk("wd_single", wd[0], 1'b0);

        send_word(0, 40'hA1_A2_A3_A4_A5, 3, 0, 0, 1'b0, 1'b1);
        chk("b2b_ready", rdy[0], 1'b1);
        send_word(0, 40'hB1_B2_B3_B4_B5, 3, 0, 0, 1'b0, 1'b0);

        send_word(1, 40'h01_23_45_67_89, 4, 0, 0, 1'b0, 1'b0);

        send_word(0, 40'hC1_C2_C3_C4_C5, 5, 1, 2, 1'b0, 1'b0);
        send_word(0, 40'h5A_69_78_87_96, 2, 0, 0, 1'b0, 1'b0);

        send_word(0, 40'h10_20_30_40_50, 4, 0, 0, 1'b1, 1'b0);
        send_word(1, 40'hF0_E1_D2_C3_B4, 1, 0, 0, 1'b1, 1'b0);

        send_word(0, 40'h77_66_55_44_33, 6, 2, 2, 1'b0, 1'b0);
        send_word(0, 40'hDE_AD_BE_EF_01, 2, 0, 0, 1'b0, 1'b0);

        for (int n = 0; n < 8; n++) begin
            rw = {8'($urandom), $urandom};
            send_word(n % 2, rw, int'($urandom_range(1, 12)), 0, 0, 1'($urandom_range(0, 1)), 1'b0);
        end

        repeat (3) tick();
        for (int i = 0; i < 2; i++) begin
            chk("word_done_count", wd_cnt[i], exp_wd[i]);
            chk("tx_err_count", err_cnt[i], exp_err[i]);
            chk("start_pulse_count", pulse_cnt[i], exp_p[i]);
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
